// File: rtl/usbf_ssram_arb.sv
// Single-port SSRAM arbiter: the internal DMA engine normally wins, and a starvation
// counter forces a pending host (WISHBONE) access through after MAX_WAIT lost cycles.
module usbf_ssram_arb #(
  parameter int SSRAM_HADR = 14,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SSRAM_HADR:0]   madr,
  input  logic [31:0]           mdout,
  input  logic                  mwe,
  input  logic                  mreq,
  output logic                  mack,
  output logic [31:0]           mdin,
  input  logic [SSRAM_HADR:0]   wadr,
  input  logic [31:0]           wdin,
  input  logic                  wwe,
  input  logic                  wreq,
  output logic                  wack,
  output logic [31:0]           wdout,
  output logic [SSRAM_HADR:0]   sram_adr,
  output logic [31:0]           sram_dout,
  output logic                  sram_we,
  output logic                  sram_re,
  input  logic [31:0]           sram_din,
  output logic                  host_starved
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic {ARB = 1'b0, HACK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                host_starved_q, host_starved_d;
  logic [SSRAM_HADR:0] adr_q, adr_d;

  logic                host_elig, force_grant, g_host, g_dma, granted;
  logic [SSRAM_HADR:0] win_adr;
  logic [31:0]         win_dout;
  logic                win_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ARB;
      wait_cnt_q     <= 4'd0;
      host_starved_q <= 1'b0;
      adr_q          <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      host_starved_q <= host_starved_d;
      adr_q          <= adr_d;
    end
  end

  always_comb begin
    host_elig      = wreq & (state_q == ARB);
    force_grant    = host_elig & (wait_cnt_q == MAX_WAIT_C);
    g_host         = host_elig & (force_grant | ~mreq);
    g_dma          = mreq & ~g_host;
    granted        = g_host | g_dma;

    win_adr        = g_host ? wadr : madr;
    win_dout       = g_host ? wdin : mdout;
    win_we         = g_host ? wwe  : mwe;

    state_d        = g_host ? HACK : ARB;
    host_starved_d = host_starved_q | force_grant;
    adr_d          = granted ? win_adr : adr_q;

    wait_cnt_d = wait_cnt_q;
    if (g_host || !wreq) begin
      wait_cnt_d = 4'd0;
    end else if (host_elig && wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Strobes and the DMA grant are gated by rst so nothing reaches the macro during reset.
  always_comb begin
    sram_adr     = granted ? win_adr : adr_q;
    sram_dout    = win_dout;
    sram_we      = granted & win_we & rst;
    sram_re      = granted & ~win_we & rst;
    mack         = g_dma & rst;
    wack         = (state_q == HACK);
    mdin         = sram_din;
    wdout        = sram_din;
    host_starved = host_starved_q;
  end

endmodule

// File: tb/tb_usbf_ssram_arb.sv
// Directed bench for usbf_ssram_arb: stimulus pushes expectations, a negedge monitor
// pops and compares them against grants, acknowledges and per-cycle probes.
module tb_usbf_ssram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] madr, wadr, sram_adr;
  logic [31:0] mdout, mdin, wdin, wdout, sram_dout, sram_din;
  logic        mwe, mreq, mack, wwe, wreq, wack, sram_we, sram_re, host_starved;

  always #5 clk = ~clk;

  usbf_ssram_arb #(.SSRAM_HADR(14), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .madr(madr), .mdout(mdout), .mwe(mwe), .mreq(mreq), .mack(mack), .mdin(mdin),
    .wadr(wadr), .wdin(wdin), .wwe(wwe), .wreq(wreq), .wack(wack), .wdout(wdout),
    .sram_adr(sram_adr), .sram_dout(sram_dout), .sram_we(sram_we), .sram_re(sram_re),
    .sram_din(sram_din), .host_starved(host_starved)
  );

  // SSRAM macro model with one-cycle read latency
  logic [31:0] mem [0:32767];
  logic [31:0] rd_q;
  assign sram_din = rd_q;
  always @(posedge clk) begin
    if (sram_we) mem[sram_adr] <= sram_dout;
    if (sram_re) rd_q <= mem[sram_adr];
  end

  typedef struct { logic [14:0] adr; logic we; logic [31:0] data; } dma_exp_t;
  typedef struct { logic rd; logic [31:0] data; } host_exp_t;
  typedef struct { int sig; logic [31:0] exp; } probe_t;

  localparam int P_MACK = 0, P_WACK = 1, P_WE = 2, P_RE = 3, P_STARVED = 4,
                 P_ADR = 5, P_DOUT = 6, P_WCNT = 7, P_QEMPTY = 8;

  dma_exp_t  dma_q[$];
  host_exp_t host_q[$];
  probe_t    probe_q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: all comparisons happen here, on the falling edge
  initial begin
    logic        mdin_pend;
    logic [31:0] mdin_exp;
    dma_exp_t    de;
    host_exp_t   he;
    probe_t      p;
    mdin_pend = 1'b0;
    mdin_exp  = '0;
    forever begin
      @(negedge clk);
      if (mdin_pend) begin
        check("dma_mdin", mdin, mdin_exp);
        mdin_pend = 1'b0;
      end
      if (mack === 1'b1) begin
        if (dma_q.size() == 0) begin
          check("mack_unexpected", {31'b0, mack}, 32'd0);
        end else begin
          de = dma_q.pop_front();
          $display("dma grant adr=0x%03h we=%0d", sram_adr, sram_we);
          check("dma_adr", {17'b0, sram_adr}, {17'b0, de.adr});
          check("dma_we", {31'b0, sram_we}, {31'b0, de.we});
          if (de.we) check("dma_dout", sram_dout, de.data);
          else begin
            mdin_pend = 1'b1;
            mdin_exp  = de.data;
          end
        end
      end
      if (wack === 1'b1) begin
        if (host_q.size() == 0) begin
          check("wack_unexpected", {31'b0, wack}, 32'd0);
        end else begin
          he = host_q.pop_front();
          $display("host ack wdout=0x%08h rd=%0d", wdout, he.rd);
          if (he.rd) check("host_wdout", wdout, he.data);
        end
      end
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        case (p.sig)
          P_MACK:    check("mack", {31'b0, mack}, p.exp);
          P_WACK:    check("wack", {31'b0, wack}, p.exp);
          P_WE:      check("sram_we", {31'b0, sram_we}, p.exp);
          P_RE:      check("sram_re", {31'b0, sram_re}, p.exp);
          P_STARVED: check("host_starved", {31'b0, host_starved}, p.exp);
          P_ADR:     check("sram_adr", {17'b0, sram_adr}, p.exp);
          P_DOUT:    check("sram_dout", sram_dout, p.exp);
          P_WCNT:    check("wait_cnt", {28'b0, dut.wait_cnt_q}, p.exp);
          default:   check("queues_empty", dma_q.size() + host_q.size(), p.exp);
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int sig, input logic [31:0] exp);
    probe_q.push_back('{sig, exp});
  endtask

  task automatic dma_drive(input logic [14:0] adr, input logic we, input logic [31:0] data);
    madr  = adr;
    mwe   = we;
    mdout = we ? data : 32'h0;
    mreq  = 1'b1;
    dma_q.push_back('{adr, we, data});
  endtask

  // Host access with DMA idle: granted in the issue cycle, ack the cycle after.
  task automatic host_acc(input logic [14:0] adr, input logic we, input logic [31:0] wdata,
                          input logic [31:0] exp_rd);
    logic got;
    wadr = adr; wwe = we; wdin = wdata; wreq = 1'b1;
    host_q.push_back('{~we, exp_rd});
    probe(P_ADR, {17'b0, adr});
    probe(P_WE, {31'b0, we});
    probe(P_RE, {31'b0, ~we});
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      cyc();
      if (wack === 1'b1) got = 1'b1;
    end
    if (!got) probe(P_WACK, 32'd1);
    else begin
      probe(P_RE, 32'd0);
      probe(P_WE, 32'd0);
    end
    cyc();
    wreq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; mreq = 1'b1; mwe = 1'b1; madr = 15'h055; mdout = 32'h11111111;
    wreq = 1'b1; wwe = 1'b0; wadr = 15'h010; wdin = 32'h0;
    probe(P_MACK, 0); probe(P_WE, 0); probe(P_RE, 0); probe(P_WACK, 0); probe(P_STARVED, 0);
    cyc(); cyc();
    mreq = 1'b0; wreq = 1'b0; rst = 1'b1;
    cyc();

    // Preload word 0x010 through the DMA port, then host read of it
    dma_drive(15'h010, 1'b1, 32'hDEADBEEF);
    cyc();
    mreq = 1'b0;
    host_acc(15'h010, 1'b0, 32'h0, 32'hDEADBEEF);

    // DMA write burst, one grant per cycle
    for (int i = 0; i < 8; i++) begin
      dma_drive(15'h100 + 15'(i), 1'b1, 32'hA5A50000 + 32'(i));
      cyc();
    end
    mreq = 1'b0;
    host_acc(15'h103, 1'b0, 32'h0, 32'hA5A50003);
    host_acc(15'h107, 1'b0, 32'h0, 32'hA5A50007);

    // Contention without starvation: host write wins once mreq drops
    wreq = 1'b1; wwe = 1'b1; wadr = 15'h020; wdin = 32'h12345678;
    host_q.push_back('{1'b0, 32'h0});
    dma_drive(15'h200, 1'b1, 32'h0BAD0000); probe(P_STARVED, 0); probe(P_WCNT, 0);
    cyc();
    dma_drive(15'h201, 1'b1, 32'h0BAD0001); probe(P_WCNT, 1);
    cyc();
    mreq = 1'b0;
    probe(P_WE, 1); probe(P_ADR, 32'h020); probe(P_DOUT, 32'h12345678); probe(P_WCNT, 2);
    cyc();
    probe(P_WACK, 1); probe(P_WCNT, 0); probe(P_STARVED, 0);
    cyc();
    wreq = 1'b0;

    // DMA reads back-to-back: host-written word and a burst word
    dma_drive(15'h020, 1'b0, 32'h12345678);
    cyc();
    dma_drive(15'h201, 1'b0, 32'h0BAD0001);
    cyc();
    mreq = 1'b0;
    cyc();

    // Starvation: DMA held high, host forced through on cycle 4
    wreq = 1'b1; wwe = 1'b0; wadr = 15'h010;
    host_q.push_back('{1'b1, 32'hDEADBEEF});
    for (int c = 0; c < 4; c++) begin
      dma_drive(15'h100, 1'b0, 32'hA5A50000);
      probe(P_WCNT, 32'(c));
      if (c == 3) probe(P_STARVED, 0);
      cyc();
    end
    probe(P_MACK, 0); probe(P_RE, 1); probe(P_ADR, 32'h010); probe(P_WCNT, 4);
    cyc();
    dma_drive(15'h100, 1'b0, 32'hA5A50000);
    probe(P_WACK, 1); probe(P_STARVED, 1);
    cyc();
    mreq = 1'b0; wreq = 1'b0;
    probe(P_STARVED, 1);
    cyc();

    // Asynchronous reset asserted in the host grant cycle
    wreq = 1'b1; wwe = 1'b0; wadr = 15'h010;
    #2;
    rst = 1'b0; mreq = 1'b1; mwe = 1'b1; madr = 15'h300; mdout = 32'hCAFEF00D;
    probe(P_MACK, 0); probe(P_WE, 0); probe(P_RE, 0);
    cyc();
    probe(P_WACK, 0); probe(P_WCNT, 0); probe(P_MACK, 0); probe(P_WE, 0); probe(P_STARVED, 0);
    cyc();
    mreq = 1'b0; wreq = 1'b0; rst = 1'b1;
    probe(P_WACK, 0);
    cyc();
    host_acc(15'h010, 1'b0, 32'h0, 32'hDEADBEEF);

    repeat (3) cyc();
    probe(P_QEMPTY, 0);
    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
